des_dec_key_sched: RTL and testbench

- Iterative DES decryption key schedule for the DES core.
- Loads a 64-bit key and applies PC-1.
- Emits the 16 round subkeys in decryption order, K16 first and K1 last, one per accepted handshake.
- Generates subkeys by right-rotating C/D, so the datapath never has to precompute and store all 16 subkeys.

---
 rtl/des_dec_key_sched.sv | 139 +++++++++++++
 tb/tb_des_dec_key_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/des_dec_key_sched.sv
// Iterative DES key schedule: PC-1 at load, then one subkey per accepted handshake, K16 first.
// Optional `DES_KS_ENC_MODE_EN adds enc_mode for encryption order (K1 first).
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        key_load,
`ifdef DES_KS_ENC_MODE_EN
  input  logic        enc_mode,
`endif
  output logic        key_ready,
  output logic [47:0] sk_out,
  output logic [3:0]  sk_idx,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // DES bit n lives at vector index (width - n); tables are 1-based DES numbering.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    pc1 = '0;
    for (int unsigned i = 0; i < 56; i++) pc1[55-i] = k[64-PC1_TAB[i]];
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    pc2 = '0;
    for (int unsigned i = 0; i < 48; i++) pc2[47-i] = cd[56-PC2_TAB[i]];
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] v, input logic left, input logic two);
    case ({left, two})
      2'b00:   rot = {v[0], v[27:1]};
      2'b01:   rot = {v[1:0], v[27:2]};
      2'b10:   rot = {v[26:0], v[27]};
      default: rot = {v[25:0], v[27:26]};
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]  r_rnd, w_rnd_nxt;
  logic        r_done, w_done_nxt;
  logic [55:0] w_pc1;
  logic [3:0]  w_rnd_inc;
  logic        w_two;
  logic        w_enc_load;
  logic        w_enc_run;

`ifdef DES_KS_ENC_MODE_EN
  logic r_enc;
  assign w_enc_load = enc_mode;
  assign w_enc_run  = r_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_enc <= 1'b0;
    else if (r_state == S_IDLE && key_load) r_enc <= enc_mode;
  end
`else
  assign w_enc_load = 1'b0;
  assign w_enc_run  = 1'b0;
`endif

  assign w_pc1     = pc1(key_in);
  assign w_rnd_inc = r_rnd + 4'd1;
  // Shift schedule is palindromic, so decrypt-right and encrypt-left share it: 1 at steps 1, 8, 15.
  assign w_two     = !(w_rnd_inc == 4'd1 || w_rnd_inc == 4'd8 || w_rnd_inc == 4'd15);

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_rnd_nxt   = r_rnd;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_load) begin
          w_state_nxt = S_RUN;
          w_rnd_nxt   = '0;
          if (w_enc_load) begin
            w_c_nxt = rot(w_pc1[55:28], 1'b1, 1'b0);
            w_d_nxt = rot(w_pc1[27:0],  1'b1, 1'b0);
          end else begin
            w_c_nxt = w_pc1[55:28];
            w_d_nxt = w_pc1[27:0];
          end
        end
      end
      default: begin
        if (sk_ready) begin
          if (r_rnd == 4'd15) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_rnd_nxt = w_rnd_inc;
            w_c_nxt   = rot(r_c, w_enc_run, w_two);
            w_d_nxt   = rot(r_d, w_enc_run, w_two);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_rnd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_rnd   <= w_rnd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign key_ready = (r_state == S_IDLE);
  assign sk_valid  = (r_state == S_RUN);
  assign done      = r_done;
  assign sk_out    = pc2({r_c, r_d});
  assign sk_idx    = w_enc_run ? r_rnd : (4'd15 - r_rnd);

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Directed bench for des_dec_key_sched using the classic 133457799BBCDFF1 key schedule.
module tb_des_dec_key_sched;

  typedef struct {
    logic [3:0]  idx;
    logic [47:0] sk;
  } vec_t;

  localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] OTHER = 64'h0123456789ABCDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        key_load;
  logic        key_ready;
  logic [47:0] sk_out;
  logic [3:0]  sk_idx;
  logic        sk_valid;
  logic        sk_ready;
  logic        done;
`ifdef DES_KS_ENC_MODE_EN
  logic        enc_mode;
`endif

  vec_t        kv [16];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  des_dec_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_load (key_load),
`ifdef DES_KS_ENC_MODE_EN
    .enc_mode (enc_mode),
`endif
    .key_ready(key_ready),
    .sk_out   (sk_out),
    .sk_idx   (sk_idx),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals;
    chk("rst_key_ready", 64'(key_ready), 64'd1);
    chk("rst_sk_valid",  64'(sk_valid),  64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_sk_out",    64'(sk_out),    64'd0);
    chk("rst_sk_idx",    64'(sk_idx),    64'd15);
  endtask

  task automatic load(input logic [63:0] k);
    chk("load_key_ready", 64'(key_ready), 64'd1);
    key_in   = k;
    key_load = 1'b1;
    tick;
    key_load = 1'b0;
  endtask

  // Walks a decryption run from step 'start'; expected subkey only advances on a transfer.
  task automatic drain(input int unsigned start, input bit rnd_rdy, input bit inject);
    int unsigned step = start;
    int unsigned cyc  = 0;
    while (step < 16 && cyc < 300) begin
      chk("sk_valid", 64'(sk_valid), 64'd1);
      chk("sk_idx",   64'(sk_idx),   64'(kv[15-step].idx));
      chk("sk_out",   64'(sk_out),   64'(kv[15-step].sk));
      chk("key_ready_run", 64'(key_ready), 64'd0);
      chk("done_run",      64'(done),      64'd0);
      sk_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      key_load = (inject && step == 3) ? 1'b1 : 1'b0;
      key_in   = inject ? OTHER : KEY;
      if (sk_ready) step++;
      tick;
      cyc++;
    end
    key_load = 1'b0;
    sk_ready = 1'b1;
    if (step < 16) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got step %0d expected 16", step);
    end
    chk("done_pulse",    64'(done),      64'd1);
    chk("done_kready",   64'(key_ready), 64'd1);
    chk("done_sk_valid", 64'(sk_valid),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kv[0]  = '{4'd0,  48'h1B02EFFC7072};
    kv[1]  = '{4'd1,  48'h79AED9DBC9E5};
    kv[2]  = '{4'd2,  48'h55FC8A42CF99};
    kv[3]  = '{4'd3,  48'h72ADD6DB351D};
    kv[4]  = '{4'd4,  48'h7CEC07EB53A8};
    kv[5]  = '{4'd5,  48'h63A53E507B2F};
    kv[6]  = '{4'd6,  48'hEC84B7F618BC};
    kv[7]  = '{4'd7,  48'hF78A3AC13BFB};
    kv[8]  = '{4'd8,  48'hE0DBEBEDE781};
    kv[9]  = '{4'd9,  48'hB1F347BA464F};
    kv[10] = '{4'd10, 48'h215FD3DED386};
    kv[11] = '{4'd11, 48'h7571F59467E9};
    kv[12] = '{4'd12, 48'h97C5D1FABA41};
    kv[13] = '{4'd13, 48'h5F43B7F2E73A};
    kv[14] = '{4'd14, 48'hBF918D3D3F0A};
    kv[15] = '{4'd15, 48'hCB3D8B0E17F5};

    rst_n    = 1'b0;
    key_in   = '0;
    key_load = 1'b0;
    sk_ready = 1'b0;
`ifdef DES_KS_ENC_MODE_EN
    enc_mode = 1'b0;
`endif
    #12;
    chk_reset_vals();
    rst_n = 1'b1;
    tick;
    chk_reset_vals();

    // sk_ready while idle must not start anything
    sk_ready = 1'b1;
    tick;
    chk("idle_sk_valid", 64'(sk_valid), 64'd0);

    // Full run, ready held high
    load(KEY);
    drain(0, 1'b0, 1'b0);

    // Back-to-back load in the done cycle, then random backpressure
    key_in   = KEY;
    key_load = 1'b1;
    tick;
    key_load = 1'b0;
    chk("b2b_done_clear", 64'(done),   64'd0);
    chk("b2b_idx",        64'(sk_idx), 64'd15);
    drain(0, 1'b1, 1'b0);
    tick;
    chk("done_one_cycle", 64'(done),      64'd0);
    chk("idle_kready",    64'(key_ready), 64'd1);

    // key_load during RUN with another key is ignored
    load(KEY);
    drain(0, 1'b0, 1'b1);
    tick;
    chk("inj_done_clear", 64'(done), 64'd0);

    // Async reset after 5 transfers
    load(KEY);
    sk_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst_idx", 64'(sk_idx), 64'(kv[15-i].idx));
      chk("pre_rst_sk",  64'(sk_out), 64'(kv[15-i].sk));
      tick;
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    #1;
    rst_n = 1'b1;
    tick;
    chk("post_rst_done",  64'(done),     64'd0);
    chk("post_rst_valid", 64'(sk_valid), 64'd0);
    tick;
    chk("post_rst_done2", 64'(done),     64'd0);
    load(KEY);
    drain(0, 1'b0, 1'b0);
    tick;

`ifdef DES_KS_ENC_MODE_EN
    enc_mode = 1'b1;
    load(KEY);
    enc_mode = 1'b0;
    sk_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("enc_valid", 64'(sk_valid), 64'd1);
      chk("enc_idx",   64'(sk_idx),   64'(kv[i].idx));
      chk("enc_sk",    64'(sk_out),   64'(kv[i].sk));
      tick;
    end
    chk("enc_done", 64'(done),      64'd1);
    chk("enc_kr",   64'(key_ready), 64'd1);
    tick;
    // decryption order resumes once enc_mode is low at load
    load(KEY);
    chk("dec_after_enc_idx", 64'(sk_idx), 64'd15);
    chk("dec_after_enc_sk",  64'(sk_out), 64'(kv[15].sk));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
